// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine sequencer.
// Holds the controller state encoding, coin/change denominations and the
// product price table.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_e;

    localparam int COIN_100_VAL = 100;
    localparam int COIN_500_VAL = 500;
    localparam int CHANGE_UNIT  = 100;

    // Price of each product slot, in currency units.
    function automatic logic [10:0] price_of(input logic [1:0] item);
        logic [10:0] p;
        case (item)
            2'd0:    p = 11'd300;
            2'd1:    p = 11'd500;
            2'd2:    p = 11'd700;
            2'd3:    p = 11'd1200;
            default: p = 11'd1200;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Board-side bundle of the vending sequencer: raw buttons and switches in,
// credit display and actuator pulses out.
// The master side is the board and panel, and the slave side is the sequencer.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 11
);
    logic                coin_100;
    logic                coin_500;
    logic                cancel;
    logic                sel_valid;
    logic [1:0]          sel_item;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [1:0]          item_out;
    logic                change_100;
    logic                coin_reject;
    logic                insufficient;
    logic                busy;

    modport master (
        output coin_100, coin_500, cancel, sel_valid, sel_item,
        input  credit, dispense, item_out, change_100, coin_reject, insufficient, busy
    );

    modport slave (
        input  coin_100, coin_500, cancel, sel_valid, sel_item,
        output credit, dispense, item_out, change_100, coin_reject, insufficient, busy
    );
endinterface

// File: rtl/vend_sequencer_btn_cond.sv
// Button conditioner: a two-flop synchroniser, an optional debounce stage,
// and a registered rising-edge detector.
// Each press produces exactly one single-cycle event.
// Optional feature macro: DEBOUNCE_EN. When it is defined, the synchronised
// level must hold for DEBOUNCE_CYC cycles before it is accepted.
module btn_cond
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);
    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;
    logic evt_r;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;

    // Accept a new level only after it has held for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync2_r;
`endif

    // Turn each rising edge of the conditioned level into a single-cycle event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r <= 1'b0;
            evt_r  <= 1'b0;
        end else begin
            prev_r <= level_s;
            evt_r  <= level_s & ~prev_r;
        end
    end

    assign evt = evt_r;
endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer.
// It conditions the panel buttons, accumulates credit and checks the price
// of the selected product. It then pulses the dispenser and returns change
// in 100-unit pulses.
// Optional feature macro: DEBOUNCE_EN, which enables button debouncing in btn_cond.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_W     = 11,
    parameter int MAX_CREDIT   = 1500,
    parameter int CHANGE_GAP   = 4,
    parameter int DEBOUNCE_CYC = 16
)(
    input  logic           clk,
    input  logic           reset,
    vend_sequencer_if.slave bus
);
    localparam int                  GAP_W      = (CHANGE_GAP > 2) ? $clog2(CHANGE_GAP) : 1;
    localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(CHANGE_GAP - 1);
    localparam logic [CREDIT_W-1:0] UNIT       = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W+1)'(MAX_CREDIT);

    logic c100_ev_s, c500_ev_s, cancel_ev_s, sel_ev_s;

`ifdef DEBOUNCE_EN
    btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_c100   (.clk(clk), .reset(reset), .btn(bus.coin_100),  .evt(c100_ev_s));
    btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_c500   (.clk(clk), .reset(reset), .btn(bus.coin_500),  .evt(c500_ev_s));
    btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cancel (.clk(clk), .reset(reset), .btn(bus.cancel),    .evt(cancel_ev_s));
    btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sel    (.clk(clk), .reset(reset), .btn(bus.sel_valid), .evt(sel_ev_s));
`else
    btn_cond u_c100   (.clk(clk), .reset(reset), .btn(bus.coin_100),  .evt(c100_ev_s));
    btn_cond u_c500   (.clk(clk), .reset(reset), .btn(bus.coin_500),  .evt(c500_ev_s));
    btn_cond u_cancel (.clk(clk), .reset(reset), .btn(bus.cancel),    .evt(cancel_ev_s));
    btn_cond u_sel    (.clk(clk), .reset(reset), .btn(bus.sel_valid), .evt(sel_ev_s));
`endif

    vend_state_e         state_r, state_nxt_s;
    logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
    logic [1:0]          item_r, item_nxt_s;
    logic [GAP_W-1:0]    gap_r, gap_nxt_s;
    logic                dispense_r, change_r, reject_r, insuff_r, busy_r;
    logic                dispense_s, change_s, reject_s, insuff_s, busy_s;

    logic [CREDIT_W:0]   coin_val_s, sum_s, price_s;
    logic                coin_hit_s, coin_fit_s, sel_ok_s, credit_nz_s;

    // Arithmetic shared by both FSM processes (sums kept one bit wider so nothing wraps)
    always_comb begin
        if (c500_ev_s) begin
            coin_val_s = (CREDIT_W+1)'(COIN_500_VAL);
        end else if (c100_ev_s) begin
            coin_val_s = (CREDIT_W+1)'(COIN_100_VAL);
        end else begin
            coin_val_s = '0;
        end
        coin_hit_s  = c500_ev_s | c100_ev_s;
        sum_s       = {1'b0, credit_r} + coin_val_s;
        coin_fit_s  = coin_hit_s && (sum_s <= MAX_C);
        price_s     = (CREDIT_W+1)'(price_of(bus.sel_item));
        sel_ok_s    = (price_s <= {1'b0, credit_r});
        credit_nz_s = (credit_r != '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: coins take priority over cancel, and cancel over select
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (coin_fit_s) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (coin_hit_s) begin
                    state_nxt_s = COLLECT;
                end else if (cancel_ev_s && credit_nz_s) begin
                    state_nxt_s = CHANGE;
                end else if (sel_ev_s && sel_ok_s) begin
                    state_nxt_s = VEND;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            VEND: begin
                if (credit_nz_s) begin
                    state_nxt_s = CHANGE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CHANGE: begin
                if (!credit_nz_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CHANGE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with the state being entered
    always_comb begin
        credit_nxt_s = credit_r;
        item_nxt_s   = item_r;
        gap_nxt_s    = gap_r;
        dispense_s   = 1'b0;
        change_s     = 1'b0;
        reject_s     = 1'b0;
        insuff_s     = 1'b0;
        busy_s       = (state_nxt_s == VEND) || (state_nxt_s == CHANGE);
        case (state_r)
            IDLE, COLLECT: begin
                if (coin_hit_s) begin
                    // With both coins at once the 100 is always the one refused
                    reject_s = ~coin_fit_s | (c500_ev_s & c100_ev_s);
                    if (coin_fit_s) begin
                        credit_nxt_s = sum_s[CREDIT_W-1:0];
                    end else begin
                        credit_nxt_s = credit_r;
                    end
                end else if ((state_r == COLLECT) && cancel_ev_s && credit_nz_s) begin
                    change_s     = 1'b1;
                    credit_nxt_s = credit_r - UNIT;
                    gap_nxt_s    = GAP_RELOAD;
                end else if ((state_r == COLLECT) && sel_ev_s) begin
                    if (sel_ok_s) begin
                        dispense_s   = 1'b1;
                        item_nxt_s   = bus.sel_item;
                        credit_nxt_s = credit_r - price_s[CREDIT_W-1:0];
                    end else begin
                        insuff_s     = 1'b1;
                    end
                end else begin
                    credit_nxt_s = credit_r;
                end
            end
            VEND: begin
                reject_s = coin_hit_s;
                if (credit_nz_s) begin
                    change_s     = 1'b1;
                    credit_nxt_s = credit_r - UNIT;
                    gap_nxt_s    = GAP_RELOAD;
                end else begin
                    credit_nxt_s = credit_r;
                end
            end
            CHANGE: begin
                reject_s = coin_hit_s;
                if (credit_nz_s && (gap_r == '0)) begin
                    change_s     = 1'b1;
                    credit_nxt_s = credit_r - UNIT;
                    gap_nxt_s    = GAP_RELOAD;
                end else if (credit_nz_s) begin
                    gap_nxt_s    = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
                end else begin
                    gap_nxt_s    = gap_r;
                end
            end
            default: begin
                credit_nxt_s = credit_r;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_r   <= '0;
            item_r     <= 2'd0;
            gap_r      <= '0;
            dispense_r <= 1'b0;
            change_r   <= 1'b0;
            reject_r   <= 1'b0;
            insuff_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            credit_r   <= credit_nxt_s;
            item_r     <= item_nxt_s;
            gap_r      <= gap_nxt_s;
            dispense_r <= dispense_s;
            change_r   <= change_s;
            reject_r   <= reject_s;
            insuff_r   <= insuff_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.credit       = credit_r;
    assign bus.item_out     = item_r;
    assign bus.dispense     = dispense_r;
    assign bus.change_100   = change_r;
    assign bus.coin_reject  = reject_r;
    assign bus.insufficient = insuff_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer.
// Stimulus is made of button presses, and the expected results come from a
// credit-arithmetic model of the vending rules.
`timescale 1ns/1ps
module tb_vend_sequencer;
    localparam int CREDIT_W   = 11;
    localparam int MAX_CREDIT = 1500;
    localparam int CHANGE_GAP = 4;
`ifdef DEBOUNCE_EN
    localparam int DEB = 16;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT    = 3 + DEB;
    localparam int SETTLE = LAT + 90;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vend_sequencer_if #(.CREDIT_W(CREDIT_W)) bus();

    vend_sequencer #(
        .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT),
        .CHANGE_GAP(CHANGE_GAP), .DEBOUNCE_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    int n_disp = 0, n_chg = 0, n_rej = 0, n_ins = 0;
    int gap_bad = 0, busy_bad = 0, cyc = 0, last_chg = -1000;
    int price_tab [4] = '{300, 500, 700, 1200};
    int m_credit = 0;
    int m_item   = 0;

    // Pulse monitor: counts single-cycle outputs and flags bad change spacing
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (bus.dispense) begin
                n_disp <= n_disp + 1;
                if (!bus.busy) busy_bad <= busy_bad + 1;
            end
            if (bus.change_100) begin
                n_chg <= n_chg + 1;
                if (!bus.busy) busy_bad <= busy_bad + 1;
                if ((cyc - last_chg) != CHANGE_GAP && (cyc - last_chg) < 3 * CHANGE_GAP)
                    gap_bad <= gap_bad + 1;
                last_chg <= cyc;
            end
            if (bus.coin_reject)  n_rej <= n_rej + 1;
            if (bus.insufficient) n_ins <= n_ins + 1;
        end
    end

    function automatic int hold_len();
`ifdef DEBOUNCE_EN
        return 20 + int'($urandom_range(0, 3));
`else
        return 1 + int'($urandom_range(0, 3));
`endif
    endfunction

    task automatic press(input bit c1, input bit c5, input bit cn, input bit sv);
        int h;
        h = hold_len();
        @(negedge clk);
        bus.coin_100 = c1; bus.coin_500 = c5; bus.cancel = cn; bus.sel_valid = sv;
        repeat (h) @(negedge clk);
        bus.coin_100 = 1'b0; bus.coin_500 = 1'b0; bus.cancel = 1'b0; bus.sel_valid = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.coin_100 = 1'b0; bus.coin_500 = 1'b0; bus.cancel = 1'b0;
        bus.sel_valid = 1'b0; bus.sel_item = 2'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.credit !== 11'd0)     begin fails++; $display("FAIL reset_credit got %0d exp 0", bus.credit); end
        tests_run++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        tests_run++; if (bus.dispense !== 1'b0)    begin fails++; $display("FAIL reset_dispense got %0b exp 0", bus.dispense); end
        tests_run++; if (bus.change_100 !== 1'b0)  begin fails++; $display("FAIL reset_change got %0b exp 0", bus.change_100); end
        tests_run++; if (bus.coin_reject !== 1'b0) begin fails++; $display("FAIL reset_reject got %0b exp 0", bus.coin_reject); end
        tests_run++; if (bus.insufficient !== 1'b0) begin fails++; $display("FAIL reset_insuff got %0b exp 0", bus.insufficient); end
        tests_run++; if (bus.item_out !== 2'd0)    begin fails++; $display("FAIL reset_item got %0d exp 0", bus.item_out); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++; if (bus.credit !== 11'd0)     begin fails++; $display("FAIL reset_release_credit got %0d exp 0", bus.credit); end
    endtask

    task automatic test_vend_exact();
        int d0, c0, r0;
        d0 = n_disp; c0 = n_chg; r0 = n_rej;
        @(negedge clk);
        bus.coin_500 = 1'b1;
        repeat (LAT) @(negedge clk);
        tests_run++; if (bus.credit !== 11'd0)   begin fails++; $display("FAIL latency_early got %0d exp 0", bus.credit); end
        @(negedge clk);
        tests_run++; if (bus.credit !== 11'd500) begin fails++; $display("FAIL latency_credit got %0d exp 500", bus.credit); end
        bus.coin_500 = 1'b0;
        repeat (SETTLE) @(negedge clk);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.credit !== 11'd1000) begin fails++; $display("FAIL vend_credit1000 got %0d exp 1000", bus.credit); end
        bus.sel_item = 2'd2;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (n_disp - d0 !== 1)      begin fails++; $display("FAIL vend_dispense got %0d exp 1", n_disp - d0); end
        tests_run++; if (bus.item_out !== 2'd2)  begin fails++; $display("FAIL vend_item got %0d exp 2", bus.item_out); end
        tests_run++; if (n_chg - c0 !== 3)       begin fails++; $display("FAIL vend_change got %0d exp 3", n_chg - c0); end
        tests_run++; if (n_rej - r0 !== 0)       begin fails++; $display("FAIL vend_reject got %0d exp 0", n_rej - r0); end
        tests_run++; if (bus.credit !== 11'd0)   begin fails++; $display("FAIL vend_credit_end got %0d exp 0", bus.credit); end
        tests_run++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL vend_busy_end got %0b exp 0", bus.busy); end
        m_item = 2;
    endtask

    task automatic test_insufficient();
        int i0, d0, c0;
        i0 = n_ins; d0 = n_disp;
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.credit !== 11'd300) begin fails++; $display("FAIL insuff_credit300 got %0d exp 300", bus.credit); end
        bus.sel_item = 2'd3;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (n_ins - i0 !== 1)       begin fails++; $display("FAIL insuff_pulse got %0d exp 1", n_ins - i0); end
        tests_run++; if (n_disp - d0 !== 0)      begin fails++; $display("FAIL insuff_dispense got %0d exp 0", n_disp - d0); end
        tests_run++; if (bus.credit !== 11'd300) begin fails++; $display("FAIL insuff_credit_kept got %0d exp 300", bus.credit); end
        c0 = n_chg;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (n_chg - c0 !== 3)       begin fails++; $display("FAIL cancel_change got %0d exp 3", n_chg - c0); end
        tests_run++; if (bus.credit !== 11'd0)   begin fails++; $display("FAIL cancel_credit got %0d exp 0", bus.credit); end
    endtask

    task automatic test_max_credit();
        int r0, c0;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.credit !== 11'd1200) begin fails++; $display("FAIL max_credit1200 got %0d exp 1200", bus.credit); end
        r0 = n_rej;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (n_rej - r0 !== 1)        begin fails++; $display("FAIL max_reject500 got %0d exp 1", n_rej - r0); end
        tests_run++; if (bus.credit !== 11'd1200) begin fails++; $display("FAIL max_kept1200 got %0d exp 1200", bus.credit); end
        r0 = n_rej;
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.credit !== 11'd1500) begin fails++; $display("FAIL max_credit1500 got %0d exp 1500", bus.credit); end
        tests_run++; if (n_rej - r0 !== 0)        begin fails++; $display("FAIL max_noreject got %0d exp 0", n_rej - r0); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (n_rej - r0 !== 1)        begin fails++; $display("FAIL max_reject100 got %0d exp 1", n_rej - r0); end
        tests_run++; if (bus.credit !== 11'd1500) begin fails++; $display("FAIL max_kept1500 got %0d exp 1500", bus.credit); end
        c0 = n_chg;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (n_chg - c0 !== 15)       begin fails++; $display("FAIL max_refund got %0d exp 15", n_chg - c0); end
    endtask

    task automatic test_both_coins();
        int r0, c0;
        r0 = n_rej;
        press(1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.credit !== 11'd500) begin fails++; $display("FAIL both_credit got %0d exp 500", bus.credit); end
        tests_run++; if (n_rej - r0 !== 1)       begin fails++; $display("FAIL both_reject got %0d exp 1", n_rej - r0); end
        c0 = n_chg;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (n_chg - c0 !== 5)       begin fails++; $display("FAIL both_refund got %0d exp 5", n_chg - c0); end
    endtask

    task automatic test_coin_while_busy();
        int r0, c0, d0;
        bit seen;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        r0 = n_rej; c0 = n_chg; d0 = n_disp;
        bus.sel_item = 2'd0;
        seen = 1'b0;
        @(negedge clk);
        bus.sel_valid = 1'b1;
        for (int i = 0; i < LAT + 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.dispense) seen = 1'b1;
        end
        bus.sel_valid = 1'b0;
        tests_run++; if (seen !== 1'b1) begin fails++; $display("FAIL busy_dispense_timeout got %0b exp 1", seen); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (n_rej - r0 !== 1)      begin fails++; $display("FAIL busy_reject got %0d exp 1", n_rej - r0); end
        tests_run++; if (n_chg - c0 !== 7)      begin fails++; $display("FAIL busy_change got %0d exp 7", n_chg - c0); end
        tests_run++; if (n_disp - d0 !== 1)     begin fails++; $display("FAIL busy_dispense got %0d exp 1", n_disp - d0); end
        tests_run++; if (bus.credit !== 11'd0)  begin fails++; $display("FAIL busy_credit got %0d exp 0", bus.credit); end
        m_item = 0;
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_glitch();
        int r0, c0;
        r0 = n_rej;
        @(negedge clk);
        bus.coin_100 = 1'b1;
        repeat (5) @(negedge clk);
        bus.coin_100 = 1'b0;
        repeat (SETTLE) @(negedge clk);
        tests_run++; if (bus.credit !== 11'd0)   begin fails++; $display("FAIL glitch_credit got %0d exp 0", bus.credit); end
        tests_run++; if (n_rej - r0 !== 0)       begin fails++; $display("FAIL glitch_reject got %0d exp 0", n_rej - r0); end
        @(negedge clk);
        bus.coin_100 = 1'b1;
        repeat (20) @(negedge clk);
        bus.coin_100 = 1'b0;
        repeat (SETTLE) @(negedge clk);
        tests_run++; if (bus.credit !== 11'd100) begin fails++; $display("FAIL debounce_credit got %0d exp 100", bus.credit); end
        c0 = n_chg;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (n_chg - c0 !== 1)       begin fails++; $display("FAIL debounce_refund got %0d exp 1", n_chg - c0); end
    endtask
`endif

    task automatic test_reset_mid_change();
        int c0;
        bit seen;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        bus.sel_item = 2'd0;
        seen = 1'b0;
        @(negedge clk);
        bus.sel_valid = 1'b1;
        for (int i = 0; i < LAT + 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.change_100) seen = 1'b1;
        end
        bus.sel_valid = 1'b0;
        reset = 1'b0;
        tests_run++; if (seen !== 1'b1) begin fails++; $display("FAIL midchg_timeout got %0b exp 1", seen); end
        #1;
        tests_run++; if (bus.credit !== 11'd0) begin fails++; $display("FAIL midchg_credit got %0d exp 0", bus.credit); end
        tests_run++; if (bus.busy !== 1'b0)    begin fails++; $display("FAIL midchg_busy got %0b exp 0", bus.busy); end
        repeat (3) @(negedge clk);
        c0 = n_chg;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        tests_run++; if (n_chg - c0 !== 0)     begin fails++; $display("FAIL midchg_pulses got %0d exp 0", n_chg - c0); end
        tests_run++; if (bus.credit !== 11'd0) begin fails++; $display("FAIL midchg_credit_after got %0d exp 0", bus.credit); end
        m_credit = 0;
        m_item   = 0;
    endtask

    task automatic test_random();
        int op, item, v, e_disp, e_chg, e_rej, e_ins;
        int d0, c0, r0, i0;
        for (int k = 0; k < 30; k++) begin
            op   = int'($urandom_range(0, 3));
            item = int'($urandom_range(0, 3));
            e_disp = 0; e_chg = 0; e_rej = 0; e_ins = 0;
            d0 = n_disp; c0 = n_chg; r0 = n_rej; i0 = n_ins;
            bus.sel_item = 2'(item);
            if (op <= 1) begin
                v = (op == 0) ? 100 : 500;
                if (m_credit + v <= MAX_CREDIT) m_credit += v;
                else e_rej = 1;
                press(op == 0, op == 1, 1'b0, 1'b0);
            end else if (op == 2) begin
                e_chg = m_credit / 100;
                m_credit = 0;
                press(1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                if (m_credit > 0 && price_tab[item] > m_credit) begin
                    e_ins = 1;
                end else if (m_credit > 0) begin
                    e_disp = 1;
                    m_item = item;
                    e_chg  = (m_credit - price_tab[item]) / 100;
                    m_credit = 0;
                end
                press(1'b0, 1'b0, 1'b0, 1'b1);
            end
            tests_run++; if (int'(bus.credit) !== m_credit) begin fails++; $display("FAIL rnd_credit op%0d got %0d exp %0d", k, bus.credit, m_credit); end
            tests_run++; if (n_disp - d0 !== e_disp)        begin fails++; $display("FAIL rnd_dispense op%0d got %0d exp %0d", k, n_disp - d0, e_disp); end
            tests_run++; if (n_chg - c0 !== e_chg)          begin fails++; $display("FAIL rnd_change op%0d got %0d exp %0d", k, n_chg - c0, e_chg); end
            tests_run++; if (n_rej - r0 !== e_rej)          begin fails++; $display("FAIL rnd_reject op%0d got %0d exp %0d", k, n_rej - r0, e_rej); end
            tests_run++; if (n_ins - i0 !== e_ins)          begin fails++; $display("FAIL rnd_insuff op%0d got %0d exp %0d", k, n_ins - i0, e_ins); end
            tests_run++; if (int'(bus.item_out) !== m_item) begin fails++; $display("FAIL rnd_item op%0d got %0d exp %0d", k, bus.item_out, m_item); end
        end
    endtask

    task automatic test_protocol();
        tests_run++; if (gap_bad !== 0)  begin fails++; $display("FAIL change_spacing got %0d exp 0", gap_bad); end
        tests_run++; if (busy_bad !== 0) begin fails++; $display("FAIL busy_during_pulse got %0d exp 0", busy_bad); end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_insufficient();
        test_max_credit();
        test_both_coins();
        test_coin_while_busy();
`ifdef DEBOUNCE_EN
        test_glitch();
`endif
        test_reset_mid_change();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
